// File: rtl/alu_issue_arbiter_pkg.sv
// Shared constants and helpers for the ALU issue arbiter slice.
package alu_issue_arbiter_pkg;

   localparam int DATA_W_DEF   = 4;
   localparam int PIPE_LAT_DEF = 2;
   localparam int REQ_N        = 2;
   localparam int FIFO_DEPTH   = 2;
   localparam int CRED_W       = 2;

   localparam logic [CRED_W-1:0] CRED_ZERO = 2'd0;
   localparam logic [CRED_W-1:0] CRED_ONE  = 2'd1;
   localparam logic [CRED_W-1:0] CRED_MAX  = 2'd2;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_NAND = 3'b101;
   localparam logic [2:0] OP_NOR  = 3'b110;
   localparam logic [2:0] OP_XNOR = 3'b111;

   // Next credit count: +1 on issue, -1 on pop, unchanged when both or neither.
   function automatic logic [CRED_W-1:0] credit_next(input logic [CRED_W-1:0] cnt,
                                                     input logic inc,
                                                     input logic dec);
      logic [CRED_W-1:0] res;
      case ({inc, dec})
         2'b10:   res = cnt + CRED_ONE;
         2'b01:   res = cnt - CRED_ONE;
         default: res = cnt;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/alu_issue_arbiter_chk.sv
// Invariant checks for the issue arbiter: no push into a full buffer, credits bounded.
module alu_issue_arbiter_chk
   import alu_issue_arbiter_pkg::*;
(
   input logic              clock,
   input logic              resetN,
   input logic              push0,
   input logic              full0,
   input logic              push1,
   input logic              full1,
   input logic [CRED_W-1:0] cnt0,
   input logic [CRED_W-1:0] cnt1
);

   a_no_push_full0: assert property (@(posedge clock) disable iff (!resetN) !(push0 && full0));
   a_no_push_full1: assert property (@(posedge clock) disable iff (!resetN) !(push1 && full1));
   a_cnt0_bound:    assert property (@(posedge clock) disable iff (!resetN) cnt0 <= CRED_MAX);
   a_cnt1_bound:    assert property (@(posedge clock) disable iff (!resetN) cnt1 <= CRED_MAX);

endmodule

// File: rtl/alu_issue_arbiter_rsp_fifo2.sv
// Two-entry first-word-fall-through response buffer holding result plus parity.
module rsp_fifo2
   import alu_issue_arbiter_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clock,
   input  logic              resetN,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              push_parity,
   input  logic              pop,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic              parity,
   output logic              full
);

   logic [DATA_W-1:0]     mem_data_r [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] mem_par_r;
   logic                  wr_ptr_r;
   logic                  rd_ptr_r;
   logic [1:0]            count_r;
   logic                  do_push_s;
   logic                  do_pop_s;

   // Credits upstream keep pushes away from a full buffer; pops only act on a real head.
   always_comb begin
      do_pop_s  = pop && (count_r != 2'd0);
      do_push_s = push && (count_r != 2'd2);
   end

   // Storage, pointers and occupancy; both pointers wrap mod 2.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         mem_data_r[0] <= '0;
         mem_data_r[1] <= '0;
         mem_par_r     <= 2'b00;
         wr_ptr_r      <= 1'b0;
         rd_ptr_r      <= 1'b0;
         count_r       <= 2'd0;
      end else begin
         if (do_push_s) begin
            mem_data_r[wr_ptr_r] <= push_data;
            mem_par_r[wr_ptr_r]  <= push_parity;
            wr_ptr_r             <= ~wr_ptr_r;
         end
         if (do_pop_s) begin
            rd_ptr_r <= ~rd_ptr_r;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + 2'd1;
            2'b01:   count_r <= count_r - 2'd1;
            default: count_r <= count_r;
         endcase
      end
   end

   // Head of buffer is presented straight from storage.
   always_comb begin
      valid  = (count_r != 2'd0);
      full   = (count_r == 2'd2);
      data   = mem_data_r[rd_ptr_r];
      parity = mem_par_r[rd_ptr_r];
   end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Round-robin issue of two requesters into the shared ALU pipeline, with owner
// tracking and credit-protected per-requester response buffers.
module alu_issue_arbiter
   import alu_issue_arbiter_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int PIPE_LAT = PIPE_LAT_DEF
) (
   input  logic              clock,
   input  logic              resetN,
   input  logic              req0Valid,
   input  logic [DATA_W-1:0] req0A,
   input  logic [DATA_W-1:0] req0B,
   input  logic [2:0]        req0Op,
   output logic              req0Ready,
   input  logic              req1Valid,
   input  logic [DATA_W-1:0] req1A,
   input  logic [DATA_W-1:0] req1B,
   input  logic [2:0]        req1Op,
   output logic              req1Ready,
   output logic [DATA_W-1:0] aluA,
   output logic [DATA_W-1:0] aluB,
   output logic [7:0]        aluInstr,
   input  logic [DATA_W-1:0] aluX,
   input  logic              aluParity,
   output logic              rsp0Valid,
   output logic [DATA_W-1:0] rsp0Data,
   output logic              rsp0Parity,
   input  logic              rsp0Ready,
   output logic              rsp1Valid,
   output logic [DATA_W-1:0] rsp1Data,
   output logic              rsp1Parity,
   input  logic              rsp1Ready,
   output logic              idle
);

   logic                rr_ptr_r;      // 0: requester 0 wins a tie
   logic [CRED_W-1:0]   cnt0_r;
   logic [CRED_W-1:0]   cnt1_r;
   logic [CRED_W-1:0]   cnt0_nxt_s;
   logic [CRED_W-1:0]   cnt1_nxt_s;
   logic                idle_r;
   logic [DATA_W-1:0]   alu_a_r;
   logic [DATA_W-1:0]   alu_b_r;
   logic [7:0]          alu_instr_r;
   logic [PIPE_LAT:0]   tag_valid_r;
   logic [PIPE_LAT:0]   tag_id_r;

   logic                elig0_s;
   logic                elig1_s;
   logic                grant0_s;
   logic                grant1_s;
   logic                grant_any_s;
   logic [DATA_W-1:0]   sel_a_s;
   logic [DATA_W-1:0]   sel_b_s;
   logic [2:0]          sel_op_s;
   logic                push0_s;
   logic                push1_s;
   logic                pop0_s;
   logic                pop1_s;
   logic                full0_s;
   logic                full1_s;

   // Eligibility and round-robin grant; a lone eligible requester always wins.
   always_comb begin
      elig0_s  = req0Valid && (cnt0_r < CRED_MAX);
      elig1_s  = req1Valid && (cnt1_r < CRED_MAX);
      grant0_s = 1'b0;
      grant1_s = 1'b0;
      if (elig0_s && elig1_s) begin
         if (rr_ptr_r == 1'b0) begin
            grant0_s = 1'b1;
         end else begin
            grant1_s = 1'b1;
         end
      end else if (elig0_s) begin
         grant0_s = 1'b1;
      end else if (elig1_s) begin
         grant1_s = 1'b1;
      end else begin
         grant0_s = 1'b0;
         grant1_s = 1'b0;
      end
      grant_any_s = grant0_s || grant1_s;
      req0Ready   = grant0_s;
      req1Ready   = grant1_s;
   end

   // Operand/op mux feeding the issue register.
   always_comb begin
      if (grant1_s) begin
         sel_a_s  = req1A;
         sel_b_s  = req1B;
         sel_op_s = req1Op;
      end else begin
         sel_a_s  = req0A;
         sel_b_s  = req0B;
         sel_op_s = req0Op;
      end
   end

   // Tag pipe output steers the returning result; pops only count on a real head.
   always_comb begin
      push0_s    = tag_valid_r[PIPE_LAT] && (tag_id_r[PIPE_LAT] == 1'b0);
      push1_s    = tag_valid_r[PIPE_LAT] && (tag_id_r[PIPE_LAT] == 1'b1);
      pop0_s     = rsp0Ready && rsp0Valid;
      pop1_s     = rsp1Ready && rsp1Valid;
      cnt0_nxt_s = credit_next(cnt0_r, grant0_s, pop0_s);
      cnt1_nxt_s = credit_next(cnt1_r, grant1_s, pop1_s);
   end

   // Issue register, round-robin pointer, credits and idle flag.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         alu_a_r     <= '0;
         alu_b_r     <= '0;
         alu_instr_r <= 8'h00;
         rr_ptr_r    <= 1'b0;
         cnt0_r      <= CRED_ZERO;
         cnt1_r      <= CRED_ZERO;
         idle_r      <= 1'b1;
      end else begin
         if (grant_any_s) begin
            alu_a_r     <= sel_a_s;
            alu_b_r     <= sel_b_s;
            alu_instr_r <= 8'd1 << sel_op_s;
            rr_ptr_r    <= grant0_s;
         end else begin
            alu_instr_r <= 8'h00;
         end
         cnt0_r <= cnt0_nxt_s;
         cnt1_r <= cnt1_nxt_s;
         idle_r <= (cnt0_nxt_s == CRED_ZERO) && (cnt1_nxt_s == CRED_ZERO);
      end
   end

   // Owner tags ride alongside the datapath; stage PIPE_LAT lines up with aluX.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         tag_valid_r <= '0;
         tag_id_r    <= '0;
      end else begin
         tag_valid_r <= {tag_valid_r[PIPE_LAT-1:0], grant_any_s};
         tag_id_r    <= {tag_id_r[PIPE_LAT-1:0], grant1_s};
      end
   end

   assign aluA     = alu_a_r;
   assign aluB     = alu_b_r;
   assign aluInstr = alu_instr_r;
   assign idle     = idle_r;

   rsp_fifo2 #(.DATA_W(DATA_W)) u_rsp0 (
      .clock       (clock),
      .resetN      (resetN),
      .push        (push0_s),
      .push_data   (aluX),
      .push_parity (aluParity),
      .pop         (rsp0Ready),
      .valid       (rsp0Valid),
      .data        (rsp0Data),
      .parity      (rsp0Parity),
      .full        (full0_s)
   );

   rsp_fifo2 #(.DATA_W(DATA_W)) u_rsp1 (
      .clock       (clock),
      .resetN      (resetN),
      .push        (push1_s),
      .push_data   (aluX),
      .push_parity (aluParity),
      .pop         (rsp1Ready),
      .valid       (rsp1Valid),
      .data        (rsp1Data),
      .parity      (rsp1Parity),
      .full        (full1_s)
   );

   alu_issue_arbiter_chk u_chk (
      .clock  (clock),
      .resetN (resetN),
      .push0  (push0_s),
      .full0  (full0_s),
      .push1  (push1_s),
      .full1  (full1_s),
      .cnt0   (cnt0_r),
      .cnt1   (cnt1_r)
   );

endmodule
